// File: rtl/par_stream_gen.sv
// Streaming row-parity generator/checker with per-frame column parity (BCC)
// and a saturating parity-error counter. One output register, 1-cycle latency.
module par_stream_gen #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              odd_mode,
  input  logic              chk_en,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_err,
  output logic              out_last,
  output logic [DATA_W-1:0] out_bcc,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] col_par;
  logic              row_par;
  logic              accept;
  logic              handshake;

  assign in_ready  = !rst && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign row_par   = ^in_data;
  assign col_par   = (state == IDLE) ? in_data : (acc ^ in_data);

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = in_last ? IDLE : IN_FRAME;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_par   <= 1'b0;
      out_err   <= 1'b0;
      out_last  <= 1'b0;
      out_bcc   <= '0;
    end else if (accept) begin
      acc       <= in_last ? '0 : col_par;
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_par   <= chk_en ? in_par : (row_par ^ odd_mode);
      out_err   <= chk_en && ((row_par ^ in_par) != odd_mode);
      out_last  <= in_last;
      out_bcc   <= in_last ? col_par : '0;
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

  // Counted on the output handshake so a stalled error beat is counted once.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      err_cnt <= '0;
    end else if (handshake && out_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_par_stream_gen.sv
// Randomized and directed bench for par_stream_gen against a beat-level model
// that keeps the current frame's words in a queue and folds them at the last beat.
module tb_par_stream_gen;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst, odd_mode, chk_en, cnt_clr;
  logic          in_valid, in_ready, in_par, in_last;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_par, out_err, out_last;
  logic [DW-1:0] out_data, out_bcc;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  par_stream_gen #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .chk_en(chk_en), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_par(in_par),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_par(out_par), .out_err(out_err), .out_last(out_last),
    .out_bcc(out_bcc), .err_cnt(err_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected output beat and error count
  bit          m_valid, m_par, m_err, m_last, fresh;
  logic [DW-1:0] m_data, m_bcc;
  int          m_cnt;
  logic [DW-1:0] frame_q[$];

  task automatic model_reset();
    m_valid = 0; m_par = 0; m_err = 0; m_last = 0;
    m_data = '0; m_bcc = '0; m_cnt = 0; frame_q.delete(); fresh = 1;
  endtask

  task automatic cycle();
    bit acc_ok, hs, p;
    @(negedge clk);
    check("in_ready", in_ready, !rst && (!m_valid || out_ready));
    check("out_valid", out_valid, m_valid);
    if (m_valid || fresh) begin
      check("out_data", out_data, m_data);
      check("out_par", out_par, m_par);
      check("out_err", out_err, m_err);
      check("out_last", out_last, m_last);
      check("out_bcc", out_bcc, m_bcc);
    end
    check("err_cnt", err_cnt, m_cnt);
    acc_ok = in_valid && !rst && (!m_valid || out_ready);
    hs = m_valid && out_ready;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (cnt_clr) m_cnt = 0;
      else if (hs && m_err && m_cnt < (1 << CW) - 1) m_cnt++;
      if (acc_ok) begin
        p = ($countones(in_data) % 2) == 1;
        m_valid = 1;
        m_data  = in_data;
        m_par   = chk_en ? in_par : (p ^ odd_mode);
        m_err   = chk_en && ((p ^ in_par) != odd_mode);
        m_last  = in_last;
        frame_q.push_back(in_data);
        m_bcc = '0;
        if (in_last) begin
          foreach (frame_q[i]) m_bcc ^= frame_q[i];
          frame_q.delete();
        end
        fresh = 0;
      end else if (hs) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic drv(input bit v, input logic [DW-1:0] d, input bit par, input bit last,
                     input bit odd, input bit chk, input bit rdy, input bit clr);
    in_valid = v; in_data = d; in_par = par; in_last = last;
    odd_mode = odd; chk_en = chk; out_ready = rdy; cnt_clr = clr;
    cycle();
  endtask

  logic [DW-1:0] words[4] = '{8'h00, 8'h01, 8'hFF, 8'h80};

  initial begin
    model_reset();
    rst = 1;
    drv(0, '0, 0, 0, 0, 0, 1, 0);
    drv(0, '0, 0, 0, 0, 0, 1, 0);
    rst = 0;

    // generate mode, even then odd
    for (int m = 0; m < 2; m++)
      foreach (words[i]) drv(1, words[i], 0, 1, m[0], 0, 1, 0);
    drv(0, '0, 0, 0, 0, 0, 1, 0);
    // odd_mode toggled every beat
    for (int i = 0; i < 8; i++) drv(1, DW'($urandom), 0, 0, i[0], 0, 1, 0);
    drv(1, 8'h5A, 0, 1, 0, 0, 1, 0);
    drv(0, '0, 0, 0, 0, 0, 1, 1);

    // check mode with a stalled error beat
    drv(1, 8'h03, 0, 1, 0, 1, 1, 0);
    drv(1, 8'h07, 0, 1, 0, 1, 1, 0);
    check("err_beat", out_err, 1'b1);
    for (int i = 0; i < 3; i++) drv(0, '0, 0, 0, 0, 1, 0, 0);
    drv(1, 8'h07, 1, 1, 0, 1, 1, 0);
    check("cnt_after_stall", err_cnt, 2'd1);
    drv(0, '0, 0, 0, 0, 0, 1, 0);

    // frame BCC
    drv(1, 8'h12, 0, 0, 0, 0, 1, 0);
    drv(1, 8'h34, 0, 0, 1, 1, 1, 0);
    check("bcc_mid", out_bcc, 8'h00);
    drv(1, 8'h56, 0, 1, 0, 0, 1, 0);
    check("bcc_0x70", out_bcc, 8'h70);
    drv(1, 8'hA5, 0, 1, 0, 0, 1, 0);
    check("bcc_single", out_bcc, 8'hA5);

    // saturation, then clear coinciding with an error handshake
    drv(0, '0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) drv(1, 8'h07, 0, 1, 0, 1, 1, 0);
    drv(1, 8'h07, 0, 1, 0, 1, 1, 0);
    check("cnt_saturated", err_cnt, 2'd3);
    drv(0, '0, 0, 0, 0, 0, 1, 1);
    check("cnt_clr_prio", err_cnt, 2'd0);

    // reset mid-frame
    drv(1, 8'hF0, 0, 0, 0, 0, 1, 0);
    rst = 1;
    drv(0, '0, 0, 0, 0, 0, 1, 0);
    rst = 0;
    check("rst_valid", out_valid, 1'b0);
    check("rst_bcc", out_bcc, 8'h00);
    drv(1, 8'h0F, 0, 1, 0, 0, 1, 0);
    check("bcc_after_rst", out_bcc, 8'h0F);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drv($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    rst = 0;
    drv(0, '0, 0, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
